// File: rtl/if_stage_param_if.sv
// if_stage_param_if: fetch-stage control, imem and IF/ID signals bundled for if_stage_param
interface if_stage_param_if #(parameter int ADDR_W = 10, parameter int DATA_W = 32, parameter int CNT_W = 32);
   logic              enable;
   logic              stall;
   logic              branch_taken;
   logic [ADDR_W-1:0] branch_target;
   logic              jump;
   logic [ADDR_W-1:0] jump_target;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_rdata;
   logic [DATA_W-1:0] instruc;
   logic [ADDR_W-1:0] pc_out;
   logic [ADDR_W-1:0] pc_plus_1;
   logic              valid;
   logic [CNT_W-1:0]  fetch_count;
   modport master (
      input  enable, stall, branch_taken, branch_target, jump, jump_target, imem_rdata,
      output imem_addr, instruc, pc_out, pc_plus_1, valid, fetch_count
   );
   modport slave (
      output enable, stall, branch_taken, branch_target, jump, jump_target, imem_rdata,
      input  imem_addr, instruc, pc_out, pc_plus_1, valid, fetch_count
   );
endinterface

// File: rtl/if_stage_param.sv
// if_stage_param: parametrised fetch stage with stall hold buffer, redirect flush and delivery counter
module if_stage_param #(
   parameter int                ADDR_W   = 10,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                CNT_W    = 32
) (
   input logic             clock,
   input logic             reset,
   if_stage_param_if.master bus
);
   logic [ADDR_W-1:0] pc_f, pc_d, target;
   logic              vld_d, hold_act, adv, redir;
   logic [DATA_W-1:0] hold_instr;
   logic [CNT_W-1:0]  cnt;
   always_comb begin
      adv    = bus.enable & ~bus.stall;
      redir  = bus.enable & (bus.branch_taken | bus.jump);
      target = bus.branch_taken ? bus.branch_target : bus.jump_target;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_f       <= RESET_PC;
         pc_d       <= RESET_PC;
         vld_d      <= 1'b0;
         hold_act   <= 1'b0;
         hold_instr <= '0;
         cnt        <= '0;
      end else begin
         if (redir) begin
            pc_f     <= target;
            pc_d     <= pc_f;
            vld_d    <= 1'b0;
            hold_act <= 1'b0;
         end else if (adv) begin
            pc_f     <= pc_f + 1'b1;
            pc_d     <= pc_f;
            vld_d    <= 1'b1;
            hold_act <= 1'b0;
         end else if (!hold_act) begin
            // first frozen cycle: capture the word before the memory output moves on
            hold_instr <= bus.imem_rdata;
            hold_act   <= 1'b1;
         end
         if (adv & vld_d & ~redir) cnt <= cnt + 1'b1;
      end
   end
   always_comb begin
      bus.imem_addr   = pc_f;
      bus.instruc     = hold_act ? hold_instr : bus.imem_rdata;
      bus.pc_out      = pc_d;
      bus.pc_plus_1   = pc_d + 1'b1;
      bus.valid       = vld_d;
      bus.fetch_count = cnt;
   end
endmodule

// File: tb/tb_if_stage_param.sv
// tb_if_stage_param: table-driven directed checks of if_stage_param, plus a 4-bit wrap instance
module tb_if_stage_param;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   if_stage_param_if #(.ADDR_W(10), .DATA_W(32), .CNT_W(32)) bus ();
   if_stage_param_if #(.ADDR_W(4), .DATA_W(8), .CNT_W(4)) wbus ();

   if_stage_param #(.ADDR_W(10), .DATA_W(32), .RESET_PC(10'd0), .CNT_W(32)) dut (
      .clock(clock), .reset(reset), .bus(bus.master));
   if_stage_param #(.ADDR_W(4), .DATA_W(8), .RESET_PC(4'd14), .CNT_W(4)) dut_w (
      .clock(clock), .reset(reset), .bus(wbus.master));

   // synchronous ROMs: main word = 0x1000_0000 + addr, wrap word = {C, addr}
   always_ff @(posedge clock) begin
      bus.imem_rdata  <= 32'h1000_0000 + {22'd0, bus.imem_addr};
      wbus.imem_rdata <= {4'hC, wbus.imem_addr};
   end

   typedef struct {
      logic        rst, en, st, br;
      logic [9:0]  bt;
      logic        j;
      logic [9:0]  jt;
      logic        v;
      logic [9:0]  pc, addr;
      logic        ci;
      logic [9:0]  ia;
      logic [31:0] cnt;
   } vec_t;

   vec_t tv[32];
   int checks = 0;
   int failures = 0;
   int cur = 0;

   function automatic vec_t mk(input logic rst, en, st, br, input logic [9:0] bt, input logic j,
                               input logic [9:0] jt, input logic v, input logic [9:0] pc, addr,
                               input logic ci, input logic [9:0] ia, input logic [31:0] cnt);
      vec_t r;
      r.rst = rst; r.en = en; r.st = st; r.br = br; r.bt = bt; r.j = j; r.jt = jt;
      r.v = v; r.pc = pc; r.addr = addr; r.ci = ci; r.ia = ia; r.cnt = cnt;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s vec=%0d got=%h exp=%h", name, cur, act, exp);
      end
   endtask

   logic [3:0] wpc[4];
   logic [3:0] wpp[4];

   initial begin
      logic [9:0] e1;
      wpc = '{4'd14, 4'd15, 4'd0, 4'd1};
      wpp = '{4'd15, 4'd0, 4'd1, 4'd2};
      //            rst en st br bt     j  jt      v  pc      addr    ci ia      cnt
      tv[0]  = mk(1, 1, 0, 0, 10'h0,  0, 10'h0,  0, 10'h0,  10'h0,  0, 10'h0,  0);
      tv[1]  = mk(0, 1, 0, 0, 10'h0,  0, 10'h0,  1, 10'h0,  10'h1,  1, 10'h0,  0);
      tv[2]  = mk(0, 1, 0, 0, 10'h0,  0, 10'h0,  1, 10'h1,  10'h2,  1, 10'h1,  1);
      tv[3]  = mk(0, 1, 0, 0, 10'h0,  0, 10'h0,  1, 10'h2,  10'h3,  1, 10'h2,  2);
      tv[4]  = mk(0, 1, 0, 0, 10'h0,  0, 10'h0,  1, 10'h3,  10'h4,  1, 10'h3,  3);
      tv[5]  = mk(0, 1, 0, 0, 10'h0,  0, 10'h0,  1, 10'h4,  10'h5,  1, 10'h4,  4);
      tv[6]  = mk(0, 1, 0, 0, 10'h0,  0, 10'h0,  1, 10'h5,  10'h6,  1, 10'h5,  5);
      tv[7]  = mk(0, 1, 1, 0, 10'h0,  0, 10'h0,  1, 10'h5,  10'h6,  1, 10'h5,  5);
      tv[8]  = mk(0, 1, 1, 0, 10'h0,  0, 10'h0,  1, 10'h5,  10'h6,  1, 10'h5,  5);
      tv[9]  = mk(0, 1, 1, 0, 10'h0,  0, 10'h0,  1, 10'h5,  10'h6,  1, 10'h5,  5);
      tv[10] = mk(0, 1, 0, 0, 10'h0,  0, 10'h0,  1, 10'h6,  10'h7,  1, 10'h6,  6);
      tv[11] = mk(0, 1, 0, 0, 10'h0,  0, 10'h0,  1, 10'h7,  10'h8,  1, 10'h7,  7);
      tv[12] = mk(0, 1, 0, 1, 10'h40, 0, 10'h0,  0, 10'h8,  10'h40, 0, 10'h0,  7);
      tv[13] = mk(0, 1, 0, 0, 10'h0,  0, 10'h0,  1, 10'h40, 10'h41, 1, 10'h40, 7);
      tv[14] = mk(0, 1, 0, 0, 10'h0,  0, 10'h0,  1, 10'h41, 10'h42, 1, 10'h41, 8);
      tv[15] = mk(0, 1, 0, 1, 10'h10, 1, 10'h20, 0, 10'h42, 10'h10, 0, 10'h0,  8);
      tv[16] = mk(0, 1, 0, 0, 10'h0,  0, 10'h0,  1, 10'h10, 10'h11, 1, 10'h10, 8);
      tv[17] = mk(0, 1, 0, 0, 10'h0,  0, 10'h0,  1, 10'h11, 10'h12, 1, 10'h11, 9);
      tv[18] = mk(0, 1, 1, 1, 10'h10, 1, 10'h20, 0, 10'h12, 10'h10, 0, 10'h0,  9);
      tv[19] = mk(0, 1, 0, 0, 10'h0,  0, 10'h0,  1, 10'h10, 10'h11, 1, 10'h10, 9);
      tv[20] = mk(0, 1, 0, 0, 10'h0,  0, 10'h0,  1, 10'h11, 10'h12, 1, 10'h11, 10);
      tv[21] = mk(0, 0, 0, 1, 10'h30, 0, 10'h0,  1, 10'h11, 10'h12, 1, 10'h11, 10);
      tv[22] = mk(0, 1, 0, 0, 10'h0,  0, 10'h0,  1, 10'h12, 10'h13, 1, 10'h12, 11);
      tv[23] = mk(0, 1, 0, 0, 10'h0,  1, 10'h3FF, 0, 10'h13, 10'h3FF, 0, 10'h0, 11);
      tv[24] = mk(0, 1, 0, 0, 10'h0,  0, 10'h0,  1, 10'h3FF, 10'h0, 1, 10'h3FF, 11);
      tv[25] = mk(0, 1, 0, 0, 10'h0,  0, 10'h0,  1, 10'h0,  10'h1,  1, 10'h0,  12);
      tv[26] = mk(0, 1, 0, 0, 10'h0,  0, 10'h0,  1, 10'h1,  10'h2,  1, 10'h1,  13);
      tv[27] = mk(0, 1, 1, 0, 10'h0,  0, 10'h0,  1, 10'h1,  10'h2,  1, 10'h1,  13);
      tv[28] = mk(0, 1, 1, 0, 10'h0,  0, 10'h0,  1, 10'h1,  10'h2,  1, 10'h1,  13);
      tv[29] = mk(1, 1, 1, 0, 10'h0,  0, 10'h0,  0, 10'h0,  10'h0,  1, 10'h2,  0);
      tv[30] = mk(0, 1, 0, 0, 10'h0,  0, 10'h0,  1, 10'h0,  10'h1,  1, 10'h0,  0);
      tv[31] = mk(0, 1, 0, 0, 10'h0,  0, 10'h0,  1, 10'h1,  10'h2,  1, 10'h1,  1);
      wbus.enable = 1'b1; wbus.stall = 1'b0; wbus.branch_taken = 1'b0; wbus.jump = 1'b0;
      wbus.branch_target = '0; wbus.jump_target = '0;
      bus.enable = 1'b1; bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.jump = 1'b0;
      bus.branch_target = '0; bus.jump_target = '0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clock);
         reset = tv[i].rst; bus.enable = tv[i].en; bus.stall = tv[i].st;
         bus.branch_taken = tv[i].br; bus.branch_target = tv[i].bt;
         bus.jump = tv[i].j; bus.jump_target = tv[i].jt;
         @(posedge clock);
         #1;
         cur = i;
         e1 = tv[i].pc + 10'd1;
         chk("valid", 64'(bus.valid), 64'(tv[i].v));
         chk("pc_out", 64'(bus.pc_out), 64'(tv[i].pc));
         chk("pc_plus_1", 64'(bus.pc_plus_1), 64'(e1));
         chk("imem_addr", 64'(bus.imem_addr), 64'(tv[i].addr));
         chk("fetch_count", 64'(bus.fetch_count), 64'(tv[i].cnt));
         if (tv[i].ci) chk("instruc", 64'(bus.instruc), 64'(32'h1000_0000 + {22'd0, tv[i].ia}));
         if (i >= 1 && i <= 4) begin
            chk("wrap_valid", 64'(wbus.valid), 64'(1'b1));
            chk("wrap_pc_out", 64'(wbus.pc_out), 64'(wpc[i-1]));
            chk("wrap_pc_plus_1", 64'(wbus.pc_plus_1), 64'(wpp[i-1]));
            chk("wrap_instruc", 64'(wbus.instruc), 64'({4'hC, wpc[i-1]}));
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/if_stage_param.md
# if_stage_param

Parametrised instruction-fetch stage for the MIPS pipeline. It generalises the fixed 10-bit fetch path with configurable address width, data width and reset vector. It adds pipeline stall handling with an instruction hold buffer, redirect flush with a valid flag, and a delivered-instruction counter. It drives an external synchronous instruction memory (1-cycle read latency) and feeds the IF/ID register.

## Interface
- ADDR_W, 10, PC / instruction-memory address width in words
- DATA_W, 32, instruction width
- RESET_PC, 0, PC value loaded on reset (ADDR_W bits)
- CNT_W, 32, width of fetch_count
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; overrides every other input
- enable  in  1  global run; 0 freezes the stage and ignores redirects
- stall  in  1  hazard-unit hold (replaces PC_write=0); 1 holds PC and output
- branch_taken  in  1  redirect to branch_target
- branch_target  in  ADDR_W  branch destination
- jump  in  1  redirect to jump_target
- jump_target  in  ADDR_W  jump destination
- imem_addr  out  ADDR_W  address to sync memory (= pc_f register)
- imem_rdata  in  DATA_W  memory data, valid 1 cycle after address
- instruc  out  DATA_W  instruction for ID
- pc_out  out  ADDR_W  PC of instruc
- pc_plus_1  out  ADDR_W  pc_out+1, modulo 2^ADDR_W
- valid  out  1  instruc/pc_out meaningful
- fetch_count  out  CNT_W  instructions delivered since reset

## Operation
- State: pc_f (address being fetched), pc_d/vld_d (tag of current imem_rdata), hold_instr/hold_act (stall buffer), fetch_count.
- freeze = ~enable | stall; adv = enable & ~stall; redir = enable & (branch_taken | jump).
- Next-PC select: branch_taken → branch_target; else jump → jump_target; else pc_f+1. Branch has priority over jump when both are asserted.
- PC arithmetic is ADDR_W-bit unsigned. 2^ADDR_W−1 + 1 wraps to 0. There is no overflow flag.
- redir (with or without stall):
  - pc_f ← selected target.
  - pc_d ← pc_f.
  - vld_d ← 0, because the in-flight fetch is flushed.
  - hold_act ← 0.
- adv without redir: pc_f ← pc_f+1, pc_d ← pc_f, vld_d ← 1, hold_act ← 0.
- freeze without redir:
  - pc_f, pc_d and vld_d are held.
  - On the first freeze cycle (hold_act=0), hold_instr ← imem_rdata and hold_act ← 1.
  - While hold_act=1, hold_instr is not rewritten.
- Outputs: instruc = hold_act ? hold_instr : imem_rdata; pc_out = pc_d; valid = vld_d.
- fetch_count increments by 1 on each cycle with adv & vld_d & ~redir, and wraps at 2^CNT_W.
- Reset sets: pc_f = pc_d = RESET_PC, vld_d = 0, hold_act = 0, hold_instr = 0, fetch_count = 0. Therefore valid=0, pc_out=RESET_PC, pc_plus_1=RESET_PC+1, instruc = imem_rdata (don't care while valid=0).

## Timing
- Fetch latency: address driven in cycle t, instruction on instruc with valid in t+1.
- After reset release with enable=1 and no stall: the first edge gives valid=1 and pc_out=RESET_PC. One instruction per cycle follows.
- Redirect asserted in cycle t:
  - t+1: valid=0 (1-cycle bubble), imem_addr=target.
  - t+2: valid=1, pc_out=target.
- Stall asserted in cycles t..t+n−1: instruc, pc_out and valid stay equal to their cycle-t values for all n cycles. At the first cycle after stall drops, the held instruction is still presented and is consumed at that edge. The next cycle presents pc_out+1 with no gap and no duplicate.
- Simultaneous stall and redirect: the redirect wins, the buffer is discarded, and the bubble follows as above.
- enable=0: behaves as stall, and redirect inputs are ignored.
- Reset mid-stall or mid-redirect: reset state is reached at the next edge.

## Test plan
- Reset then run with ROM mem[i]=i: valid rises 1 cycle after reset. pc_out=0,1,2,…, instruc matches, fetch_count tracks delivered count.
- Wrap: ADDR_W=4, RESET_PC=14: pc_out sequence 14,15,0,1, with pc_plus_1=15,0,1,2.
- Stall 3 cycles at pc_out=5: instruc=mem[5] and pc_out=5 held for 3 cycles. Release gives 6 next with no repeat, and fetch_count does not increment during the stall.
- Branch to 0x40 while pc_out=7: next cycle valid=0, following cycle pc_out=0x40 with instruc=mem[0x40]. The flushed instruction at 8 is never valid.
- Branch to 0x10 and jump to 0x20 in the same cycle, also repeated with stall=1: branch wins and pc_out=0x10 after the bubble.
- Assert reset during a stall with hold_act=1: next cycle valid=0, pc_out=RESET_PC, fetch_count=0, and the hold buffer is cleared.
